instr_cycle_sequencer: RTL and testbench

//  Instruction-cycle sequencer for the non-pipelined 16-bit CPU: runs fetch -> decode -> [indirect] -> execute.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/seq_counter.sv | 22 ++
 rtl/instr_cycle_sequencer.sv | 167 ++++++++++++++++
 tb/tb_instr_cycle_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-cycle sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    INDIRECT,
    EXEC_MEM,
    EXEC_REG,
    HALT,
    FAULT
  } state_t;

  localparam logic [2:0]  OPC_REG     = 3'd7;
  localparam logic [15:0] INSTR_HLT   = 16'h7001;
  localparam logic [1:0]  ADDR_SEL_PC = 2'd0;
  localparam logic [1:0]  ADDR_SEL_AR = 2'd1;

  // Busy covers every state in which an instruction is in flight.
  function automatic logic is_busy(input state_t s);
    return !(s inside {IDLE, HALT, FAULT});
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Saturating up-counter with synchronous clear; T-state counter and memory wait counter.
module seq_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/instr_cycle_sequencer.sv
// Fetch/decode/indirect/execute sequencer for the 16-bit CPU.
// Define MEM_TIMEOUT_EN to fault on a memory read that is never acknowledged.
module instr_cycle_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned SC_W        = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [15:0]      i_ir,
  input  logic             i_mem_ack,
  input  logic             i_exec_done,
  output logic             o_mem_req,
  output logic [1:0]       o_addr_sel,
  output logic             o_ld_ir,
  output logic             o_inc_pc,
  output logic             o_ld_ar,
  output logic             o_ld_ar_ind,
  output logic             o_exec_mem,
  output logic             o_exec_reg,
  output logic [SC_W-1:0]  o_sc,
  output logic [CNT_W-1:0] o_instr_cnt,
  output logic             o_busy,
  output logic             o_halted,
  output logic             o_fault
);

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("instr_cycle_sequencer: TIMEOUT_CYC must be nonzero");
  end

  state_t           state;
  state_t           next_state;
  logic             retire;
  logic             timeout;
  logic             sc_clr;
  logic [CNT_W-1:0] instr_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and retirement strobe.
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    case (state)
      IDLE:     if (i_start) next_state = FETCH;
      FETCH: begin
        if (i_mem_ack)    next_state = DECODE;
        else if (timeout) next_state = FAULT;
      end
      DECODE: begin
        if (i_ir == INSTR_HLT) begin
          next_state = HALT;
          retire     = 1'b1;
        end else if (i_ir[14:12] == OPC_REG) begin
          next_state = EXEC_REG;
        end else if (i_ir[15]) begin
          next_state = INDIRECT;
        end else begin
          next_state = EXEC_MEM;
        end
      end
      INDIRECT: begin
        if (i_mem_ack)    next_state = EXEC_MEM;
        else if (timeout) next_state = FAULT;
      end
      EXEC_MEM: begin
        if (i_exec_done) begin
          next_state = FETCH;
          retire     = 1'b1;
        end
      end
      EXEC_REG: begin
        next_state = FETCH;
        retire     = 1'b1;
      end
      HALT:     if (i_start) next_state = FETCH;
      FAULT:    next_state = FAULT;
      default:  next_state = IDLE;
    endcase
  end

  // Moore level outputs.
  always_comb begin
    o_mem_req  = 1'b0;
    o_addr_sel = ADDR_SEL_PC;
    o_ld_ar    = 1'b0;
    o_exec_mem = 1'b0;
    o_exec_reg = 1'b0;
    o_halted   = 1'b0;
    case (state)
      FETCH:    o_mem_req = 1'b1;
      DECODE:   o_ld_ar = 1'b1;
      INDIRECT: begin
        o_mem_req  = 1'b1;
        o_addr_sel = ADDR_SEL_AR;
      end
      EXEC_MEM: o_exec_mem = 1'b1;
      EXEC_REG: o_exec_reg = 1'b1;
      HALT:     o_halted = 1'b1;
      default:  ;
    endcase
  end

  // Load strobes fire in the ack cycle; a simultaneous reset suppresses them.
  assign o_ld_ir     = (state == FETCH) && i_mem_ack && !reset;
  assign o_inc_pc    = o_ld_ir;
  assign o_ld_ar_ind = (state == INDIRECT) && i_mem_ack && !reset;
  assign o_busy      = is_busy(state);

  // T-state restarts on every entry into FETCH and only advances while busy.
  assign sc_clr = (next_state == FETCH) && (state != FETCH);

  seq_counter #(.W(SC_W)) u_sc (
    .clk   (clk),
    .reset (reset),
    .clr   (sc_clr),
    .en    (o_busy),
    .cnt   (o_sc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_cnt <= '0;
    end else if (retire) begin
      instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  assign o_instr_cnt = instr_cnt;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_clr;
  logic              wait_en;

  assign wait_clr = (o_mem_req && i_mem_ack) || (next_state != state);
  assign wait_en  = (state == FETCH) || (state == INDIRECT);

  seq_counter #(.W(WAIT_W)) u_wait (
    .clk   (clk),
    .reset (reset),
    .clr   (wait_clr),
    .en    (wait_en),
    .cnt   (wait_cnt)
  );

  // Current cycle is the TIMEOUT_CYC-th consecutive one without an ack.
  assign timeout = (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
  assign o_fault = (state == FAULT);
`else
  assign timeout = 1'b0;
  assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// Randomized self-checking bench for instr_cycle_sequencer against an instruction-level model.
module tb_instr_cycle_sequencer;

  localparam int unsigned SC_W   = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned TO_CYC = 4;
  localparam int          SC_MAX = (1 << SC_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_start;
  logic [15:0]      i_ir;
  logic             i_mem_ack;
  logic             i_exec_done;
  logic             o_mem_req;
  logic [1:0]       o_addr_sel;
  logic             o_ld_ir;
  logic             o_inc_pc;
  logic             o_ld_ar;
  logic             o_ld_ar_ind;
  logic             o_exec_mem;
  logic             o_exec_reg;
  logic [SC_W-1:0]  o_sc;
  logic [CNT_W-1:0] o_instr_cnt;
  logic             o_busy;
  logic             o_halted;
  logic             o_fault;
  logic [11:0]      obs_flags;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  int t       = 0;

  always #5 clk = ~clk;

  instr_cycle_sequencer #(
    .SC_W(SC_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_ir(i_ir),
    .i_mem_ack(i_mem_ack), .i_exec_done(i_exec_done),
    .o_mem_req(o_mem_req), .o_addr_sel(o_addr_sel), .o_ld_ir(o_ld_ir),
    .o_inc_pc(o_inc_pc), .o_ld_ar(o_ld_ar), .o_ld_ar_ind(o_ld_ar_ind),
    .o_exec_mem(o_exec_mem), .o_exec_reg(o_exec_reg), .o_sc(o_sc),
    .o_instr_cnt(o_instr_cnt), .o_busy(o_busy), .o_halted(o_halted),
    .o_fault(o_fault)
  );

  assign obs_flags = {o_mem_req, o_addr_sel, o_ld_ir, o_inc_pc, o_ld_ar, o_ld_ar_ind,
                      o_exec_mem, o_exec_reg, o_busy, o_halted, o_fault};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] fl(input bit req, input logic [1:0] sel, input bit ldir,
                                     input bit ldar, input bit ldind, input bit em, input bit er,
                                     input bit busy, input bit hlt, input bit flt);
    return {req, sel, ldir, ldir, ldar, ldind, em, er, busy, hlt, flt};
  endfunction

  function automatic int sat(input int x);
    return (x > SC_MAX) ? SC_MAX : x;
  endfunction

  // Inputs already driven; sample at negedge, then advance to just after the next posedge.
  task automatic cyc(input string tag, input logic [11:0] ef, input int esc);
    @(negedge clk);
    check({tag, "_flags"}, 32'(obs_flags), 32'(ef));
    if (esc >= 0) check({tag, "_sc"}, 32'(o_sc), 32'(esc));
    check({tag, "_cnt"}, 32'(o_instr_cnt), 32'(exp_cnt % (1 << CNT_W)));
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic noise();
    i_start     = 1'($urandom_range(0, 1));
    i_mem_ack   = 1'($urandom_range(0, 1));
    i_exec_done = 1'($urandom_range(0, 1));
  endtask

  // One whole instruction starting in its first FETCH cycle; returns in the next FETCH.
  task automatic run_instr(input logic [15:0] ir, input int fw, input int iw, input int ew,
                           input int hw);
    bit is_hlt, is_reg, is_ind;
    is_hlt = (ir == 16'h7001);
    is_reg = (ir[14:12] == 3'd7);
    is_ind = ir[15];
    i_ir   = ir;
    t      = 0;
    for (int k = 0; k <= fw; k++) begin
      noise();
      i_mem_ack = (k == fw);
      cyc("fetch", fl(1, 2'd0, k == fw, 0, 0, 0, 0, 1, 0, 0), sat(t));
    end
    noise();
    cyc("decode", fl(0, 2'd0, 0, 1, 0, 0, 0, 1, 0, 0), sat(t));
    if (is_hlt) begin
      exp_cnt++;
      for (int k = 0; k < hw; k++) begin
        noise();
        i_start = 1'b0;
        cyc("halt", fl(0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0), -1);
      end
      noise();
      i_start = 1'b1;
      cyc("halt_go", fl(0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0), -1);
    end else if (is_reg) begin
      noise();
      cyc("exec_reg", fl(0, 2'd0, 0, 0, 0, 0, 1, 1, 0, 0), sat(t));
      exp_cnt++;
    end else begin
      if (is_ind) begin
        for (int k = 0; k <= iw; k++) begin
          noise();
          i_mem_ack = (k == iw);
          cyc("indirect", fl(1, 2'd1, 0, 0, k == iw, 0, 0, 1, 0, 0), sat(t));
        end
      end
      for (int k = 0; k <= ew; k++) begin
        noise();
        i_exec_done = (k == ew);
        cyc("exec_mem", fl(0, 2'd0, 0, 0, 0, 1, 0, 1, 0, 0), sat(t));
      end
      exp_cnt++;
    end
    t = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] ir;
    int          cls;
    reset = 1'b1; i_start = 1'b0; i_mem_ack = 1'b0; i_exec_done = 1'b0; i_ir = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", 12'h000, 0);
    reset = 1'b0;
    i_mem_ack = 1'b1; i_exec_done = 1'b1;
    cyc("idle", 12'h000, 0);
    i_mem_ack = 1'b0; i_exec_done = 1'b0; i_start = 1'b1;
    cyc("idle_start", 12'h000, 0);

    run_instr(16'h7800, 0, 0, 0, 0);
    run_instr(16'h8123, 3, 3, 2, 0);
    run_instr(16'h0456, 1, 0, 20, 0);
    run_instr(16'h7001, 0, 0, 0, 3);
    run_instr(16'h7001, 2, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      cls = $urandom_range(0, 3);
      ir  = 16'($urandom);
      case (cls)
        0:       ir = 16'h7001;
        1:       ir[14:12] = 3'd7;
        2:       begin ir[15] = 1'b1; if (ir[14:12] == 3'd7) ir[14:12] = 3'd2; end
        default: begin ir[15] = 1'b0; if (ir[14:12] == 3'd7) ir[14:12] = 3'd5; end
      endcase
      run_instr(ir, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
                $urandom_range(0, 2));
    end

    for (int n = 0; n < 260; n++) run_instr(16'h7abc, 0, 0, 0, 0);

    // Reset while an indirect read is outstanding.
    i_ir = 16'h8123; t = 0;
    noise(); i_mem_ack = 1'b1;
    cyc("rst_fetch", fl(1, 2'd0, 1, 0, 0, 0, 0, 1, 0, 0), sat(t));
    noise();
    cyc("rst_decode", fl(0, 2'd0, 0, 1, 0, 0, 0, 1, 0, 0), sat(t));
    noise(); i_mem_ack = 1'b0; reset = 1'b1;
    cyc("rst_indirect", fl(1, 2'd1, 0, 0, 0, 0, 0, 1, 0, 0), sat(t));
    reset = 1'b0; exp_cnt = 0;
    i_start = 1'b0; i_mem_ack = 1'b1; i_exec_done = 1'b1;
    cyc("rst_idle", 12'h000, 0);
    cyc("rst_idle_ack", 12'h000, 0);

`ifdef MEM_TIMEOUT_EN
    i_mem_ack = 1'b0; i_exec_done = 1'b0; i_start = 1'b1;
    cyc("to_start", 12'h000, 0);
    t = 0;
    for (int k = 0; k < int'(TO_CYC); k++) begin
      i_start = 1'b0; i_mem_ack = 1'b0;
      cyc("to_fetch", fl(1, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0), sat(t));
    end
    i_start = 1'b1; i_mem_ack = 1'b1;
    cyc("to_fault", fl(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1), -1);
    cyc("to_fault_hold", fl(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1), -1);
    reset = 1'b1; i_start = 1'b0;
    cyc("to_reset", fl(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1), -1);
    reset = 1'b0; i_mem_ack = 1'b0;
    cyc("to_idle", 12'h000, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
